// File: rtl/tomasulo_pkg.sv
// Shared types for the load reservation buffer: operand widths, dispatch
// FSM states and the buffer entry layout.
package tomasulo_pkg;

    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_ISSUED = 2'd1,
        D_WAIT   = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic              valid;
        logic              rdy;
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] offset;
        logic [ROB_W-1:0]  rob;
    } lb_entry_t;

endpackage

// File: rtl/lb_oldest_ready_sel.sv
// Combinational priority picker: lowest set request bit wins, reported as
// one-hot grant, binary index and an any-request flag.
module lb_oldest_ready_sel #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan downward so the lowest-index request is the last assignment.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_buffer.sv
// Load reservation buffer: compacting queue of pending loads with CDB snoop
// and a three-state dispatch FSM. LOAD_BUFFER_STATS_EN adds stat counters.
module load_buffer
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_base_rdy,
    input  logic [DATA_W-1:0] issue_base_val,
    input  logic [ROB_W-1:0]  issue_base_tag,
    input  logic [DATA_W-1:0] issue_offset,
    input  logic [ROB_W-1:0]  issue_rob,
    input  logic              cdb_enable,
    input  logic [ROB_W-1:0]  cdb_rob,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              lu_busy,
    output logic              load_enable,
    output logic [DATA_W-1:0] load_addr,
    output logic [ROB_W-1:0]  load_rob
`ifdef LOAD_BUFFER_STATS_EN
    ,
    output logic [31:0]       stat_dispatched,
    output logic [31:0]       stat_full_cycles
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    lb_entry_t         ent_q [DEPTH];
    lb_entry_t         ent_d [DEPTH];
    lb_entry_t         snoop [DEPTH];
    lb_entry_t         new_ent;
    logic [CNT_W-1:0]  count_q, count_d, wr_idx;
    disp_state_e       state_q;
    logic              load_enable_q;
    logic [DATA_W-1:0] load_addr_q, sel_addr;
    logic [ROB_W-1:0]  load_rob_q, sel_rob;
    logic [DEPTH-1:0]  req, grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              any_ready, fire, accept;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) req[i] = ent_q[i].valid & ent_q[i].rdy;
    end

    lb_oldest_ready_sel #(.N(DEPTH), .IDX_W(IDX_W)) u_sel (
        .req_i   (req),
        .grant_o (grant),
        .idx_o   (sel_idx),
        .any_o   (any_ready)
    );

    assign issue_ready = (count_q < CNT_W'(DEPTH));
    assign fire        = (state_q == D_IDLE) && any_ready && !lu_busy && !flush;
    assign accept      = issue_valid && issue_ready && !flush;
    assign wr_idx      = fire ? count_q - CNT_W'(1) : count_q;

    always_comb begin
        sel_addr = '0;
        sel_rob  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_addr = ent_q[i].val + ent_q[i].offset;
                sel_rob  = ent_q[i].rob;
            end
        end
    end

    // Snoop first, then compact over the dispatched slot, then append the issue.
    always_comb begin
        new_ent.valid  = 1'b1;
        new_ent.rdy    = issue_base_rdy;
        new_ent.tag    = issue_base_tag;
        new_ent.val    = issue_base_val;
        new_ent.offset = issue_offset;
        new_ent.rob    = issue_rob;
        if (!issue_base_rdy && cdb_enable && (cdb_rob == issue_base_tag)) begin
            new_ent.rdy = 1'b1;
            new_ent.val = cdb_data;
        end

        for (int i = 0; i < DEPTH; i++) begin
            snoop[i] = ent_q[i];
            if (cdb_enable && ent_q[i].valid && !ent_q[i].rdy && (ent_q[i].tag == cdb_rob)) begin
                snoop[i].rdy = 1'b1;
                snoop[i].val = cdb_data;
            end
            ent_d[i] = snoop[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (fire && (i >= int'(sel_idx))) ent_d[i] = snoop[i + 1];
        end
        if (fire) ent_d[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (CNT_W'(i) == wr_idx)) ent_d[i] = new_ent;
        end

        count_d = count_q;
        if (accept && !fire)      count_d = count_q + CNT_W'(1);
        else if (!accept && fire) count_d = count_q - CNT_W'(1);

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= D_IDLE;
            load_enable_q <= 1'b0;
            load_addr_q   <= '0;
            load_rob_q    <= '0;
        end else if (flush) begin
            state_q       <= D_IDLE;
            load_enable_q <= 1'b0;
        end else begin
            case (state_q)
                D_IDLE: begin
                    load_enable_q <= 1'b0;
                    if (fire) begin
                        load_enable_q <= 1'b1;
                        load_addr_q   <= sel_addr;
                        load_rob_q    <= sel_rob;
                        state_q       <= D_ISSUED;
                    end
                end
                // One dead cycle so the load unit can raise lu_busy.
                D_ISSUED: begin
                    load_enable_q <= 1'b0;
                    state_q       <= D_WAIT;
                end
                D_WAIT: begin
                    load_enable_q <= 1'b0;
                    if (!lu_busy) state_q <= D_IDLE;
                end
                default: begin
                    load_enable_q <= 1'b0;
                    state_q       <= D_IDLE;
                end
            endcase
        end
    end

    assign load_enable = load_enable_q;
    assign load_addr   = load_addr_q;
    assign load_rob    = load_rob_q;

`ifdef LOAD_BUFFER_STATS_EN
    logic [31:0] stat_dispatched_q, stat_full_cycles_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_dispatched_q  <= '0;
            stat_full_cycles_q <= '0;
        end else begin
            if (load_enable_q)               stat_dispatched_q  <= stat_dispatched_q + 32'd1;
            if (issue_valid && !issue_ready) stat_full_cycles_q <= stat_full_cycles_q + 32'd1;
        end
    end

    assign stat_dispatched  = stat_dispatched_q;
    assign stat_full_cycles = stat_full_cycles_q;
`endif

endmodule
